// File: rtl/fwd_stall_ctrl_pkg.sv
// Shared types and constants for the forwarding / load-use stall controller.
package fwd_stall_ctrl_pkg;

  // Register x31 reads as zero, so it never creates a dependency.
  localparam logic [4:0] XZR = 5'd31;

  // One shadow pipeline entry.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } stage_t;

  // Operand source select.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Stall sequencer states.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_stall_ctrl_cmp.sv
// 5-bit equality cell used for register-number comparisons.
module comparator_5 (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic       eq
);

  assign eq = (a == b);

endmodule

// File: rtl/fwd_stall_ctrl.sv
// Forwarding select and load-use stall control for a 5-stage pipeline.
// Tracks EX and MEM destination info in a small shadow pipeline.
module fwd_stall_ctrl
  import fwd_stall_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  output logic        stall,
  output logic        id_ready,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt
);

  stage_t     ex_q;
  stage_t     mem_q;
  state_t     state_q;
  state_t     state_d;
  logic [15:0] stall_cnt_q;

  logic rn_eq_ex;
  logic rm_eq_ex;
  logic rn_eq_mem;
  logic rm_eq_mem;

  logic rn_match_ex;
  logic rm_match_ex;
  logic rn_match_mem;
  logic rm_match_mem;
  logic hazard;

  fwd_sel_t fwd_a_sel;
  fwd_sel_t fwd_b_sel;

  comparator_5 u_cmp_rn_ex  (.a(id_rn), .b(ex_q.rd),  .eq(rn_eq_ex));
  comparator_5 u_cmp_rm_ex  (.a(id_rm), .b(ex_q.rd),  .eq(rm_eq_ex));
  comparator_5 u_cmp_rn_mem (.a(id_rn), .b(mem_q.rd), .eq(rn_eq_mem));
  comparator_5 u_cmp_rm_mem (.a(id_rm), .b(mem_q.rd), .eq(rm_eq_mem));

  // A source matches an entry only if that entry will write a real register.
  always_comb begin
    rn_match_ex  = ex_q.valid  && ex_q.reg_write  && rn_eq_ex  && (id_rn != XZR);
    rm_match_ex  = ex_q.valid  && ex_q.reg_write  && rm_eq_ex  && (id_rm != XZR);
    rn_match_mem = mem_q.valid && mem_q.reg_write && rn_eq_mem && (id_rn != XZR);
    rm_match_mem = mem_q.valid && mem_q.reg_write && rm_eq_mem && (id_rm != XZR);
  end

  // Operand source selection; EX wins over MEM, loads in EX cannot forward yet.
  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (id_valid) begin
      if (rn_match_ex && !ex_q.mem_read) fwd_a_sel = FWD_EX;
      else if (rn_match_mem)             fwd_a_sel = FWD_MEM;
      if (rm_match_ex && !ex_q.mem_read) fwd_b_sel = FWD_EX;
      else if (rm_match_mem)             fwd_b_sel = FWD_MEM;
    end
  end

  assign fwd_a = fwd_a_sel;
  assign fwd_b = fwd_b_sel;

  // Stall decision and next state; a flush overrides any hazard.
  always_comb begin
    hazard  = 1'b0;
    stall   = 1'b0;
    state_d = ST_RUN;
    if (state_q == ST_RUN) begin
      hazard = id_valid && ex_q.mem_read && (rn_match_ex || rm_match_ex);
      stall  = hazard && !flush;
      if (stall) state_d = ST_STALL;
    end
  end

  assign id_ready  = ~stall;
  assign stall_cnt = stall_cnt_q;

  // Stall sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Shadow pipeline advance; a bubble enters EX when stalled, flushed or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      mem_q <= ex_q;
      if (id_valid && !stall && !flush) begin
        ex_q.valid     <= 1'b1;
        ex_q.rd        <= id_rd;
        ex_q.reg_write <= id_reg_write;
        ex_q.mem_read  <= id_mem_read;
      end else begin
        ex_q <= '0;
      end
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  end

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Directed self-checking bench for fwd_stall_ctrl.
module tb_fwd_stall_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rn;
  logic [4:0]  id_rm;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic        stall;
  logic        id_ready;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  fwd_stall_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .id_ready     (id_ready),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cnt    (stall_cnt)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one decode-stage vector at the falling edge, settle, then return.
  task automatic applyStimulus(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic fl);
    @(negedge clk);
    id_valid     = v;
    id_rn        = rn;
    id_rm        = rm;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
    #1;
  endtask

  // Two idle cycles drain both shadow entries.
  task automatic drain;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall !== 1'b0 || id_ready !== 1'b1 || fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: stall=%b ready=%b fa=%b fb=%b cnt=%h want 0 1 00 00 0000",
               stall, id_ready, fwd_a, fwd_b, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_forward;
    applyStimulus(1, 1, 2, 3, 1, 0, 0);
    applyStimulus(1, 3, 0, 10, 0, 0, 0);
    checks++;
    if (fwd_a !== 2'b01 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alu_fwd_ex: fwd_a=%b stall=%b want 01 0", fwd_a, stall);
    end
    applyStimulus(1, 3, 0, 10, 0, 0, 0);
    checks++;
    if (fwd_a !== 2'b10) begin
      errors++;
      $display("[TB] FAIL alu_fwd_mem: fwd_a=%b want 10", fwd_a);
    end
    drain();
    // Same producer, but decode slot empty: nothing may forward.
    applyStimulus(1, 1, 2, 9, 1, 0, 0);
    applyStimulus(0, 9, 9, 0, 0, 0, 0);
    checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_fwd: fa=%b fb=%b stall=%b want 00 00 0", fwd_a, fwd_b, stall);
    end
    drain();
  endtask

  task automatic test_back_to_back;
    applyStimulus(1, 1, 2, 6, 1, 0, 0);
    applyStimulus(1, 1, 2, 6, 1, 0, 0);
    applyStimulus(1, 0, 6, 0, 0, 0, 0);
    checks++;
    if (fwd_b !== 2'b01 || fwd_a !== 2'b00) begin
      errors++;
      $display("[TB] FAIL ex_over_mem: fb=%b fa=%b want 01 00", fwd_b, fwd_a);
    end
    drain();
  endtask

  task automatic test_load_use;
    applyStimulus(1, 1, 2, 5, 1, 1, 0);
    applyStimulus(1, 1, 5, 8, 0, 0, 0);
    checks++;
    if (stall !== 1'b1 || id_ready !== 1'b0 || fwd_b !== 2'b00) begin
      errors++;
      $display("[TB] FAIL load_use_stall: stall=%b ready=%b fb=%b want 1 0 00", stall, id_ready, fwd_b);
    end
    applyStimulus(1, 1, 5, 8, 0, 0, 0);
    checks++;
    if (stall !== 1'b0 || fwd_b !== 2'b10 || stall_cnt !== 16'd1) begin
      errors++;
      $display("[TB] FAIL load_use_release: stall=%b fb=%b cnt=%0d want 0 10 1", stall, fwd_b, stall_cnt);
    end
    drain();
  endtask

  task automatic test_xzr;
    applyStimulus(1, 1, 2, 31, 1, 1, 0);
    applyStimulus(1, 31, 0, 4, 0, 0, 0);
    checks++;
    if (stall !== 1'b0 || fwd_a !== 2'b00) begin
      errors++;
      $display("[TB] FAIL xzr: stall=%b fa=%b want 0 00", stall, fwd_a);
    end
    drain();
  endtask

  task automatic test_flush;
    applyStimulus(1, 1, 2, 7, 1, 1, 0);
    // Killed instruction is itself a load of r7; if it leaked into EX the next use would stall.
    applyStimulus(1, 7, 0, 7, 1, 1, 1);
    checks++;
    if (stall !== 1'b0 || stall_cnt !== 16'd1) begin
      errors++;
      $display("[TB] FAIL flush_hazard: stall=%b cnt=%0d want 0 1", stall, stall_cnt);
    end
    applyStimulus(1, 7, 0, 1, 0, 0, 0);
    checks++;
    if (stall !== 1'b0 || fwd_a !== 2'b10 || stall_cnt !== 16'd1) begin
      errors++;
      $display("[TB] FAIL flush_bubble: stall=%b fa=%b cnt=%0d want 0 10 1", stall, fwd_a, stall_cnt);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall;
    applyStimulus(1, 1, 2, 7, 1, 1, 0);
    applyStimulus(1, 7, 0, 1, 0, 0, 0);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_stall_setup: stall=%b want 1", stall);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || id_ready !== 1'b1 || stall_cnt !== 16'd0 || fwd_a !== 2'b00) begin
      errors++;
      $display("[TB] FAIL async_reset: stall=%b ready=%b cnt=%0d fa=%b want 0 1 0 00",
               stall, id_ready, stall_cnt, fwd_a);
    end
    id_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 7, 0, 1, 0, 0, 0);
    checks++;
    if (fwd_a !== 2'b00 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_reset: fa=%b stall=%b want 00 0", fwd_a, stall);
    end
    drain();
  endtask

  task automatic test_saturation;
    logic [15:0] exp_cnt;
    @(negedge clk);
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 16'hFFFD;
    // A chain of dependent loads on r5 stalls every other cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 5, 5, 1, 1, 0);
      checks++;
      if (stall !== (i % 2 == 1) || stall_cnt !== exp_cnt) begin
        errors++;
        $display("[TB] FAIL saturate_%0d: stall=%b cnt=%h want %b %h", i, stall, stall_cnt, (i % 2 == 1), exp_cnt);
      end
      if (i % 2 == 1 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    drain();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL saturate_hold: cnt=%h want ffff", stall_cnt);
    end
  endtask

  initial begin
    id_valid     = 1'b0;
    id_rn        = '0;
    id_rm        = '0;
    id_rd        = '0;
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
    flush        = 1'b0;
    test_reset();
    test_alu_forward();
    test_back_to_back();
    test_load_use();
    test_xzr();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_stall_ctrl.md
FWD_STALL_CTRL -- requirements
Module: fwd_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a valid instruction
- id_rn  in  5  first source register
- id_rm  in  5  second source register
- id_rd  in  5  destination register
- id_reg_write  in  1  decode instruction writes a register
- id_mem_read  in  1  decode instruction is a load
- flush  in  1  taken branch resolved in EX; kill decode instruction
- stall  out  1  hold fetch and decode, insert bubble into EX
- id_ready  out  1  equals ~stall
- fwd_a  out  2  operand-A source select
- fwd_b  out  2  operand-B source select
- stall_cnt  out  16  saturating count of load-use stall cycles

Function
REQ-003 The block SHALL keep a shadow pipeline of two entries, EX and MEM; each entry is {valid, rd[4:0], reg_write, mem_read}.
REQ-004 A register "matches" an entry only if all hold: entry valid, entry reg_write=1, rd equal, rd != 31 (XZR is never forwarded or stalled on).
REQ-005 fwd_a SHALL be combinational and use this priority:
- 2'b01 if id_rn matches EX and EX.mem_read=0
- else 2'b10 if id_rn matches MEM
- else 2'b00 (register file; WB uses write-through)
REQ-006 fwd_b SHALL follow the same rule using id_rm.
REQ-007 Load-use hazard = id_valid and EX.mem_read and (id_rn or id_rm matches EX).
REQ-008 stall SHALL be 1 when the FSM is in RUN with a load-use hazard and flush=0; otherwise stall SHALL be 0.
REQ-009 The FSM SHALL have states RUN and STALL:
- RUN -> STALL on a stalled cycle
- STALL -> RUN unconditionally after one cycle
- a stall therefore lasts exactly one cycle per load-use pair
REQ-010 While in STALL, hazard detection SHALL be suppressed, because the load is in MEM and fwd 2'b10 applies.
REQ-011 Each cycle the entries SHALL advance: MEM <= EX.
REQ-012 EX SHALL load the decode fields when id_valid=1, stall=0 and flush=0; otherwise EX SHALL load an invalid bubble.
REQ-013 flush SHALL have priority over stall:
- a bubble enters EX
- the FSM goes to RUN
- stall_cnt is not incremented
REQ-014 stall_cnt SHALL increment on each cycle with stall=1 and saturate at 16'hFFFF.
REQ-015 id_valid=0 SHALL force fwd_a and fwd_b to 2'b00 and SHALL produce no stall.

Reset
REQ-016 rst_n low SHALL asynchronously set:
- both entries to invalid
- FSM to RUN
- stall_cnt to 0
REQ-017 During and after reset, stall=0, id_ready=1, fwd_a=fwd_b=2'b00 until valid entries exist.
REQ-018 Reset asserted mid-stall SHALL abandon the stall; the first cycle after release SHALL be RUN with empty shadow entries.

Structure
REQ-019 A shared package SHALL hold:
- the stage-entry struct
- the fwd select enum (FWD_RF=00, FWD_EX=01, FWD_MEM=10)
- the FSM state enum
- the constant XZR=5'd31
REQ-020 The four register equality checks (rn/rm vs EX.rd and MEM.rd) SHALL each instantiate the existing 5-bit equality cell comparator_5.
REQ-021 No other sub-module is needed.
REQ-022 Target size is roughly 150-250 lines of RTL.

Verification
REQ-023 ALU forward: cycle 0 issue rd=3 reg_write=1; cycle 1 issue rn=3 -> fwd_a=01, stall=0; cycle 2 same rn -> fwd_a=10.
REQ-024 Load-use: issue load rd=5; next issue rm=5 -> stall=1 for exactly one cycle, fwd_b=10 on the following cycle, stall_cnt=1.
REQ-025 XZR: issue load rd=31, then rn=31 -> stall=0 and fwd_a=00.
REQ-026 Flush with hazard: load rd=7, then rn=7 together with flush=1 -> stall=0, bubble enters EX, stall_cnt unchanged.
REQ-027 Reset mid-stall: assert rst_n=0 while stall=1 -> stall=0 immediately, state RUN, stall_cnt=0; after release, rn=7 -> fwd_a=00.
REQ-028 Saturation: preload stall_cnt near 16'hFFFF via repeated load-use pairs -> stall_cnt holds at 16'hFFFF.
